// File: rtl/game_pkg.sv
// game_pkg: scan-code constants, letter type and decoder FSM states shared by the game datapath.
package game_pkg;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   typedef logic [4:0] letter_t;
   localparam letter_t LETTER_NONE = 5'd0;
   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;
endpackage

// File: rtl/scancode_to_letter.sv
// scancode_to_letter: PS/2 set-2 make code to letter code A=1..Z=26, LETTER_NONE otherwise.
module scancode_to_letter
   import game_pkg::*;
(
   input  logic [7:0] code,
   output letter_t    letter
);
   always_comb begin
      letter = LETTER_NONE;
      case (code)
         8'h1C: letter = 5'd1;
         8'h32: letter = 5'd2;
         8'h21: letter = 5'd3;
         8'h23: letter = 5'd4;
         8'h24: letter = 5'd5;
         8'h2B: letter = 5'd6;
         8'h34: letter = 5'd7;
         8'h33: letter = 5'd8;
         8'h43: letter = 5'd9;
         8'h3B: letter = 5'd10;
         8'h42: letter = 5'd11;
         8'h4B: letter = 5'd12;
         8'h3A: letter = 5'd13;
         8'h31: letter = 5'd14;
         8'h44: letter = 5'd15;
         8'h4D: letter = 5'd16;
         8'h15: letter = 5'd17;
         8'h2D: letter = 5'd18;
         8'h1B: letter = 5'd19;
         8'h2C: letter = 5'd20;
         8'h3C: letter = 5'd21;
         8'h2A: letter = 5'd22;
         8'h1D: letter = 5'd23;
         8'h22: letter = 5'd24;
         8'h35: letter = 5'd25;
         8'h1A: letter = 5'd26;
         default: letter = LETTER_NONE;
      endcase
   end
endmodule

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: PS/2 scan bytes to letter codes in a one-deep valid/ack slot,
// plus Enter/Backspace pulses, with break/extended prefix handling and typematic filtering.
module ps2_letter_decoder
   import game_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2500000
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_byte_en,
   input  logic       char_ack,
   output letter_t    char,
   output logic       char_valid,
   output logic       enter_pulse,
   output logic       bksp_pulse,
   output logic       overflow
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

   kbd_state_t    state;
   logic [7:0]    held_code;
   logic [CW-1:0] cnt;
   letter_t       letter;
   logic          ld;

   scancode_to_letter u_lut (.code(ps2_byte), .letter(letter));

   // a fresh (non-repeat) letter make code arriving while no prefix is pending
   assign ld = ps2_byte_en && state == IDLE && ps2_byte != held_code && letter != LETTER_NONE;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         held_code   <= 8'h00;
         cnt         <= '0;
         char        <= LETTER_NONE;
         char_valid  <= 1'b0;
         enter_pulse <= 1'b0;
         bksp_pulse  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         enter_pulse <= 1'b0;
         bksp_pulse  <= 1'b0;
         cnt         <= (ps2_byte_en || state == IDLE) ? '0 : cnt + 1'b1;
         if (ps2_byte_en) begin
            case (state)
               IDLE:
                  if (ps2_byte == SC_BREAK) state <= BRK;
                  else if (ps2_byte == SC_EXT) state <= EXT;
                  else if (ps2_byte != held_code) begin
                     held_code   <= ps2_byte;
                     enter_pulse <= ps2_byte == SC_ENTER;
                     bksp_pulse  <= ps2_byte == SC_BKSP;
                  end
               BRK:
                  if (ps2_byte != SC_BREAK) begin
                     if (ps2_byte == held_code) held_code <= 8'h00;
                     state <= IDLE;
                  end
               EXT:
                  if (ps2_byte == SC_BREAK) state <= EXT_BRK;
                  else if (ps2_byte != SC_EXT) begin
                     enter_pulse <= ps2_byte == SC_ENTER;
                     state       <= IDLE;
                  end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && cnt == CNT_MAX) state <= IDLE;
         if (ld && (!char_valid || char_ack)) begin
            char       <= letter;
            char_valid <= 1'b1;
         end else if (char_ack && char_valid) begin
            char       <= LETTER_NONE;
            char_valid <= 1'b0;
         end
         if (ld && char_valid && !char_ack) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ps2_letter_decoder.sv
// tb_ps2_letter_decoder: table of per-cycle stimulus rows with expected outputs,
// expectations queued at drive time and checked one clock later.
module tb_ps2_letter_decoder;
   import game_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] ps2_byte = 8'h00;
   logic       ps2_byte_en = 1'b0;
   logic       char_ack = 1'b0;
   letter_t    char;
   logic       char_valid, enter_pulse, bksp_pulse, overflow;

   ps2_letter_decoder #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .resetn(resetn), .ps2_byte(ps2_byte), .ps2_byte_en(ps2_byte_en),
      .char_ack(char_ack), .char(char), .char_valid(char_valid),
      .enter_pulse(enter_pulse), .bksp_pulse(bksp_pulse), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rn, en; logic [7:0] b; logic ack;
      logic [4:0] ch; logic v, ent, bk, ov;
   } vec_t;
   typedef struct {
      int idx, due;
      logic [4:0] ch; logic v, ent, bk, ov;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int cyc = 0, checks = 0, errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void add(input logic rn, en, input logic [7:0] b, input logic ack,
                               input logic [4:0] ch, input logic v, ent, bk, ov);
      vecs.push_back('{rn, en, b, ack, ch, v, ent, bk, ov});
   endfunction

   function automatic void idle(input int n, input logic [4:0] ch, input logic v, ov);
      for (int i = 0; i < n; i++) add(1, 0, 8'h00, 0, ch, v, 0, 0, ov);
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if ({char, char_valid, enter_pulse, bksp_pulse, overflow} !== {e.ch, e.v, e.ent, e.bk, e.ov}) begin
            errors++;
            $display("FAIL row%0d: got char=%0d valid=%b enter=%b bksp=%b ovf=%b, want char=%0d valid=%b enter=%b bksp=%b ovf=%b",
                     e.idx, char, char_valid, enter_pulse, bksp_pulse, overflow, e.ch, e.v, e.ent, e.bk, e.ov);
         end
      end
   end

   initial begin
      // reset state
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      // letter, break keeps the slot
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      add(1, 1, 8'hF0, 0, 1, 1, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      idle(1, 1, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // typematic repeat: exactly two letters
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'hF0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // overflow, then simultaneous ack after reset
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h32, 0, 2, 1, 0, 0, 0);
      add(1, 1, 8'h21, 0, 2, 1, 0, 0, 1);
      idle(1, 2, 1, 1);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h32, 0, 2, 1, 0, 0, 0);
      add(1, 1, 8'h21, 1, 3, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // enter / extended enter / extended break / backspace with slot full
      add(1, 1, 8'h5A, 0, 0, 0, 1, 0, 0);
      idle(1, 0, 0, 0);
      add(1, 1, 8'hE0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h5A, 0, 0, 0, 1, 0, 0);
      idle(1, 0, 0, 0);
      add(1, 1, 8'hE0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'hF0, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h5A, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      add(1, 1, 8'h66, 0, 1, 1, 0, 1, 0);
      idle(1, 1, 1, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // prefix still live before the timeout: 1A is a break code
      add(1, 1, 8'hF0, 0, 0, 0, 0, 0, 0);
      idle(10, 0, 0, 0);
      add(1, 1, 8'h1A, 0, 0, 0, 0, 0, 0);
      // prefix abandoned after the timeout: 1A is a make code
      add(1, 1, 8'hF0, 0, 0, 0, 0, 0, 0);
      idle(20, 0, 0, 0);
      add(1, 1, 8'h1A, 0, 26, 1, 0, 0, 0);
      add(1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
      // reset mid-prefix
      add(1, 1, 8'hE0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
      add(1, 1, 8'h1C, 0, 1, 1, 0, 0, 0);
      idle(1, 1, 1, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         resetn      = vecs[i].rn;
         ps2_byte_en = vecs[i].en;
         ps2_byte    = vecs[i].b;
         char_ack    = vecs[i].ack;
         sb.push_back('{i, cyc + 1, vecs[i].ch, vecs[i].v, vecs[i].ent, vecs[i].bk, vecs[i].ov});
      end
      @(negedge clk);
      ps2_byte_en = 1'b0;
      char_ack    = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
